// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI master controller.
//   spi_state_e : controller state encoding
//   BIT_CNT_W   : width of the per-byte bit counter
//   DEF_DIV / DEF_SETUP / DEF_HOLD : default timing parameters (clk cycles)
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCK_HI,
    ST_SCK_LO,
    ST_NEXT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  localparam int unsigned BIT_CNT_W = 3;

  localparam int unsigned DEF_DIV   = 2;
  localparam int unsigned DEF_SETUP = 2;
  localparam int unsigned DEF_HOLD  = 2;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: sclk half-period counter.
//   clk, rstn : system clock, asynchronous active-low reset
//   i_load    : restart the half-period (counter reloads to DIV-1)
//   o_expire  : current cycle is the last cycle of the half-period
module spi_clk_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_load,
  output logic o_expire
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= 8'(DIV - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: byte-oriented SPI master (mode 0 style, sclk idle low).
//   clk, rstn              : system clock, asynchronous active-low reset
//   req_valid/ready/data/last : byte request; last=1 releases ss after the byte
//   rsp_valid, rsp_data    : one-cycle pulse with the byte captured from miso
//   busy                   : controller not idle
//   ss, sclk, mosi, miso   : SPI bus
// Build option: define SPI_MSB_FIRST_EN to shift/assemble MSB first
// (default build is LSB first).
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DIV   = DEF_DIV,
  parameter int unsigned SETUP = DEF_SETUP,
  parameter int unsigned HOLD  = DEF_HOLD
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_data,
  input  logic       req_last,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  spi_state_e           r_state;
  logic                 r_ready;
  logic                 r_rsp_valid;
  logic [7:0]           r_rsp_data;
  logic                 r_busy;
  logic                 r_ss;
  logic                 r_sclk;
  logic                 r_mosi;
  logic [7:0]           r_tx;
  logic [7:0]           r_rx;
  logic                 r_last;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [7:0]           r_phase_cnt;

  logic w_accept;
  logic w_div_load;
  logic w_div_expire;

  // Bit-order helpers: the bit presented next, the remaining bits, and
  // assembly of a received bit.
  function automatic logic first_bit(input logic [7:0] d);
`ifdef SPI_MSB_FIRST_EN
    return d[7];
`else
    return d[0];
`endif
  endfunction

  function automatic logic [7:0] tx_shift(input logic [7:0] d);
`ifdef SPI_MSB_FIRST_EN
    return {d[6:0], 1'b0};
`else
    return {1'b0, d[7:1]};
`endif
  endfunction

  function automatic logic [7:0] rx_shift(input logic [7:0] r, input logic b);
`ifdef SPI_MSB_FIRST_EN
    return {r[6:0], b};
`else
    return {b, r[7:1]};
`endif
  endfunction

  spi_clk_div #(.DIV(DIV)) u_clk_div (
    .clk      (clk),
    .rstn     (rstn),
    .i_load   (w_div_load),
    .o_expire (w_div_expire)
  );

  // Reload the half-period counter on every edge that enters SCK_HI or SCK_LO.
  always_comb begin
    w_accept   = req_valid && r_ready;
    w_div_load = 1'b0;
    case (r_state)
      ST_SETUP:  w_div_load = (r_phase_cnt == '0);
      ST_SCK_HI: w_div_load = w_div_expire;
      ST_SCK_LO: w_div_load = w_div_expire && (r_bit_cnt != '1);
      ST_NEXT:   w_div_load = w_accept;
      default:   w_div_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
      r_ss        <= 1'b1;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_last      <= 1'b0;
      r_bit_cnt   <= '0;
      r_phase_cnt <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Ready rises on the first edge out of reset and stays up while idle.
          r_ready <= 1'b1;
          if (w_accept) begin
            r_tx        <= req_data;
            r_last      <= req_last;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_ss        <= 1'b0;
            r_phase_cnt <= 8'(SETUP - 1);
            r_state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_phase_cnt == '0) begin
            r_state <= ST_SCK_HI;
            r_sclk  <= 1'b1;
            r_mosi  <= first_bit(r_tx);
            r_tx    <= tx_shift(r_tx);
          end else begin
            r_phase_cnt <= r_phase_cnt - 8'd1;
          end
        end
        ST_SCK_HI: begin
          if (w_div_expire) begin
            r_state <= ST_SCK_LO;
            r_sclk  <= 1'b0;
            r_rx    <= rx_shift(r_rx, miso);
          end
        end
        ST_SCK_LO: begin
          if (w_div_expire) begin
            if (r_bit_cnt == '1) begin
              r_bit_cnt   <= '0;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= r_rx;
              if (r_last) begin
                r_phase_cnt <= 8'(HOLD - 1);
                r_state     <= ST_HOLD;
              end else begin
                r_ready <= 1'b1;
                r_state <= ST_NEXT;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_state   <= ST_SCK_HI;
              r_sclk    <= 1'b1;
              r_mosi    <= first_bit(r_tx);
              r_tx      <= tx_shift(r_tx);
            end
          end
        end
        ST_NEXT: begin
          // Continuation byte: first bit goes straight out from the input.
          if (w_accept) begin
            r_last  <= req_last;
            r_ready <= 1'b0;
            r_state <= ST_SCK_HI;
            r_sclk  <= 1'b1;
            r_mosi  <= first_bit(req_data);
            r_tx    <= tx_shift(req_data);
          end
        end
        ST_HOLD: begin
          if (r_phase_cnt == '0) begin
            r_ss    <= 1'b1;
            r_state <= ST_GAP;
          end else begin
            r_phase_cnt <= r_phase_cnt - 8'd1;
          end
        end
        ST_GAP: begin
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;
  assign ss        = r_ss;
  assign sclk      = r_sclk;
  assign mosi      = r_mosi;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Testbench for spi_master_ctrl: a default-parameter instance and a
// DIV=1/SETUP=1/HOLD=1 instance, selected one at a time.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       req_valid = 1'b0;
  logic [7:0] req_data = '0;
  logic       req_last = 1'b0;
  logic       tb_miso = 1'b0;
  logic       loopback = 1'b0;
  logic       sel_fast = 1'b0;

  int checks = 0;
  int errors = 0;

  logic       d_req_valid, d_req_ready, d_rsp_valid, d_busy, d_ss, d_sclk, d_mosi, d_miso;
  logic [7:0] d_rsp_data;
  logic       f_req_valid, f_req_ready, f_rsp_valid, f_busy, f_ss, f_sclk, f_mosi, f_miso;
  logic [7:0] f_rsp_data;

  logic       o_ready, o_rsp_valid, o_busy, o_ss, o_sclk, o_mosi;
  logic [7:0] o_rsp_data;

  always #5 clk = ~clk;

  assign d_req_valid = req_valid & ~sel_fast;
  assign f_req_valid = req_valid & sel_fast;
  assign d_miso      = loopback ? d_mosi : tb_miso;
  assign f_miso      = loopback ? f_mosi : tb_miso;

  assign o_ready     = sel_fast ? f_req_ready : d_req_ready;
  assign o_rsp_valid = sel_fast ? f_rsp_valid : d_rsp_valid;
  assign o_rsp_data  = sel_fast ? f_rsp_data  : d_rsp_data;
  assign o_busy      = sel_fast ? f_busy      : d_busy;
  assign o_ss        = sel_fast ? f_ss        : d_ss;
  assign o_sclk      = sel_fast ? f_sclk      : d_sclk;
  assign o_mosi      = sel_fast ? f_mosi      : d_mosi;

  spi_master_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (d_req_valid),
    .req_ready (d_req_ready),
    .req_data  (req_data),
    .req_last  (req_last),
    .rsp_valid (d_rsp_valid),
    .rsp_data  (d_rsp_data),
    .busy      (d_busy),
    .ss        (d_ss),
    .sclk      (d_sclk),
    .mosi      (d_mosi),
    .miso      (d_miso)
  );

  spi_master_ctrl #(.DIV(1), .SETUP(1), .HOLD(1)) dut_fast (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (f_req_valid),
    .req_ready (f_req_ready),
    .req_data  (req_data),
    .req_last  (req_last),
    .rsp_valid (f_rsp_valid),
    .rsp_data  (f_rsp_data),
    .busy      (f_busy),
    .ss        (f_ss),
    .sclk      (f_sclk),
    .mosi      (f_mosi),
    .miso      (f_miso)
  );

  // Reference model: the k-th bit on the wire (k = 0 first) maps to this
  // bit position of the byte, in both directions.
  function automatic int bit_pos(input int k);
`ifdef SPI_MSB_FIRST_EN
    return 7 - k;
`else
    return k;
`endif
  endfunction

  function automatic logic model_bit(input logic [7:0] d, input int k);
    return d[bit_pos(k)];
  endfunction

  // One byte transfer on the selected instance, checked against the model:
  // wire bit order, sclk timing, ss-low length, captured response, gap/idle.
  task automatic xfer(input string nm, input logic [7:0] data, input logic last,
                      input bit from_idle);
    int div_c, hold_c, exp_pre, bound, rises, pre, ss_low, ss_high, rv_cnt, hi_run, last_rise;
    logic prev_sclk, mbit, done;
    logic [7:0] exp_rx, got_rx;
    div_c   = sel_fast ? 1 : 2;
    hold_c  = sel_fast ? 1 : 2;
    exp_pre = from_idle ? (sel_fast ? 1 : 2) : 0;
    bound = 0;
    while (o_ready !== 1'b1 && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait got=%b exp=1", nm, o_ready);
      return;
    end
    req_data  = data;
    req_last  = last;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data  = 8'($urandom);
    req_last  = 1'($urandom);
    rises = 0; pre = 0; ss_low = 0; ss_high = 0; rv_cnt = 0; hi_run = 0; last_rise = 0;
    prev_sclk = 1'b0; done = 1'b0; exp_rx = '0; got_rx = '0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (o_rsp_valid === 1'b1) begin
        rv_cnt++;
        got_rx = o_rsp_data;
      end
      if (last ? (o_ss === 1'b1) : (o_ready === 1'b1)) begin
        done = 1'b1;
      end else begin
        if (o_ss === 1'b0) ss_low++; else ss_high++;
        checks++;
        if (o_busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy cyc=%0d got=%b exp=1", nm, cyc, o_busy);
        end
        if (o_sclk === 1'b1) begin
          hi_run++;
          if (prev_sclk === 1'b0) begin
            if (rises > 0) begin
              checks++;
              if (cyc - last_rise != 2 * div_c) begin
                errors++;
                $display("FAIL %s sclk_period got=%0d exp=%0d", nm, cyc - last_rise, 2 * div_c);
              end
            end
            last_rise = cyc;
            mbit = model_bit(data, rises);
            checks++;
            if (o_mosi !== mbit) begin
              errors++;
              $display("FAIL %s mosi_bit%0d got=%b exp=%b", nm, rises, o_mosi, mbit);
            end
            if (!loopback) mbit = 1'($urandom);
            tb_miso = mbit;
            exp_rx[bit_pos(rises)] = mbit;
            rises++;
          end
        end else begin
          if (prev_sclk === 1'b1) begin
            checks++;
            if (hi_run != div_c) begin
              errors++;
              $display("FAIL %s sclk_high got=%0d exp=%0d", nm, hi_run, div_c);
            end
          end
          hi_run = 0;
          if (rises == 0) pre++;
        end
        prev_sclk = o_sclk;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s end_timeout got=0 exp=1", nm);
    end
    checks++;
    if (rises != 8) begin
      errors++;
      $display("FAIL %s sclk_pulses got=%0d exp=8", nm, rises);
    end
    checks++;
    if (rv_cnt != 1) begin
      errors++;
      $display("FAIL %s rsp_valid_count got=%0d exp=1", nm, rv_cnt);
    end
    checks++;
    if (got_rx !== exp_rx) begin
      errors++;
      $display("FAIL %s rsp_data got=%h exp=%h", nm, got_rx, exp_rx);
    end
    checks++;
    if (pre != exp_pre) begin
      errors++;
      $display("FAIL %s setup_cycles got=%0d exp=%0d", nm, pre, exp_pre);
    end
    checks++;
    if (ss_low != exp_pre + 16 * div_c + (last ? hold_c : 0)) begin
      errors++;
      $display("FAIL %s ss_low_cycles got=%0d exp=%0d", nm, ss_low,
               exp_pre + 16 * div_c + (last ? hold_c : 0));
    end
    checks++;
    if (ss_high != 0) begin
      errors++;
      $display("FAIL %s ss_high_mid got=%0d exp=0", nm, ss_high);
    end
    if (last && done) begin
      checks++;
      if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s gap got ready=%b busy=%b exp ready=0 busy=1", nm, o_ready, o_busy);
      end
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_ss !== 1'b1) begin
        errors++;
        $display("FAIL %s idle got ready=%b busy=%b ss=%b exp 1 0 1", nm, o_ready, o_busy, o_ss);
      end
    end
    checks++;
    if (o_rsp_data !== exp_rx) begin
      errors++;
      $display("FAIL %s rsp_data_hold got=%h exp=%h", nm, o_rsp_data, exp_rx);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b1;
    #3 rstn = 1'b0;
    #1;
    checks++;
    if (d_ss !== 1'b1 || d_sclk !== 1'b0 || d_mosi !== 1'b0 || d_req_ready !== 1'b0 ||
        d_rsp_valid !== 1'b0 || d_rsp_data !== 8'h00 || d_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got ss=%b sclk=%b mosi=%b rdy=%b rv=%b rd=%h busy=%b exp 1 0 0 0 0 00 0",
               d_ss, d_sclk, d_mosi, d_req_ready, d_rsp_valid, d_rsp_data, d_busy);
    end
    checks++;
    if (f_ss !== 1'b1 || f_sclk !== 1'b0 || f_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_fast got ss=%b sclk=%b rdy=%b exp 1 0 0", f_ss, f_sclk, f_req_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (d_req_ready !== 1'b1 || f_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got=%b/%b exp=1/1", d_req_ready, f_req_ready);
    end
  endtask

  task automatic test_single;
    xfer("single_ab", 8'hAB, 1'b1, 1'b1);
    xfer("single_80", 8'h80, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back;
    loopback = 1'b1;
    xfer("b2b_ab", 8'hAB, 1'b0, 1'b1);
    xfer("b2b_cd", 8'hCD, 1'b1, 1'b0);
    loopback = 1'b0;
  endtask

  task automatic test_next_wait;
    xfer("next_5a", 8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b1 || o_ss !== 1'b0 || o_sclk !== 1'b0 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL next_wait cyc=%0d got rdy=%b ss=%b sclk=%b busy=%b exp 1 0 0 1",
                 i, o_ready, o_ss, o_sclk, o_busy);
      end
    end
    xfer("next_end", 8'($urandom), 1'b1, 1'b0);
  endtask

  task automatic test_reset_abort;
    int rises;
    logic prev;
    rises = 0;
    prev  = 1'b0;
    req_data  = 8'hFF;
    req_last  = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 100 && rises < 4; cyc++) begin
      @(negedge clk);
      if (o_sclk === 1'b1 && prev === 1'b0) rises++;
      prev = o_sclk;
    end
    checks++;
    if (rises != 4) begin
      errors++;
      $display("FAIL abort_reach_bit3 got=%0d exp=4", rises);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (o_ss !== 1'b1 || o_sclk !== 1'b0 || o_mosi !== 1'b0 || o_busy !== 1'b0 ||
        o_ready !== 1'b0 || o_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_immediate got ss=%b sclk=%b mosi=%b busy=%b rdy=%b rv=%b exp 1 0 0 0 0 0",
               o_ss, o_sclk, o_mosi, o_busy, o_ready, o_rsp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (o_rsp_valid !== 1'b0 || o_ss !== 1'b1) begin
        errors++;
        $display("FAIL abort_hold got rv=%b ss=%b exp 0 1", o_rsp_valid, o_ss);
      end
    end
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_release got rdy=%b rv=%b exp 1 0", o_ready, o_rsp_valid);
    end
    xfer("after_abort_01", 8'h01, 1'b1, 1'b1);
  endtask

  task automatic test_random;
    bit in_next;
    logic l;
    in_next = 1'b0;
    for (int i = 0; i < 8; i++) begin
      l = 1'($urandom);
      loopback = 1'($urandom);
      xfer("rand", 8'($urandom), l, !in_next);
      in_next = !l;
    end
    if (in_next) xfer("rand_end", 8'($urandom), 1'b1, 1'b0);
    loopback = 1'b0;
  endtask

  task automatic test_fast;
    sel_fast = 1'b1;
    loopback = 1'b1;
    xfer("fast_0f", 8'h0F, 1'b1, 1'b1);
    loopback = 1'b0;
    xfer("fast_rand0", 8'($urandom), 1'b0, 1'b1);
    xfer("fast_rand1", 8'($urandom), 1'b1, 1'b0);
    sel_fast = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_next_wait();
    test_reset_abort();
    test_random();
    test_fast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter DIV, default 2, clk cycles per sclk half-period (legal range 1..255).
REQ-002 Parameter SETUP, default 2, clk cycles from ss falling to first sclk rise (legal range 1..255).
REQ-003 Parameter HOLD, default 2, clk cycles from last sclk fall to ss rising (legal range 1..255).
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  byte transfer request.
REQ-007 req_ready  output  1  controller accepts request this cycle.
REQ-008 req_data  input  8  byte to shift out on mosi.
REQ-009 req_last  input  1  1 = deassert ss after this byte; 0 = keep ss low for next byte.
REQ-010 rsp_valid  output  1  one-cycle pulse, rsp_data valid.
REQ-011 rsp_data  output  8  byte captured from miso.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 ss  output  1  active-low slave select.
REQ-014 sclk  output  1  serial clock, idle low.
REQ-015 mosi  output  1  serial data out.
REQ-016 miso  input  1  serial data in.

Function
REQ-017 States SHALL be IDLE, SETUP, SCK_HI, SCK_LO, NEXT, HOLD, GAP.
REQ-018 req_ready SHALL be 1 only in IDLE and NEXT; transfer accepted on req_valid && req_ready.
REQ-019 IDLE accept: next cycle ss=0, state SETUP for SETUP cycles, then SCK_HI.
REQ-020 SCK_HI: sclk=1 and mosi=current bit, both updated in the same cycle, held DIV cycles.
REQ-021 SCK_LO: sclk=0, mosi held, DIV cycles; miso sampled on the last SCK_HI cycle (sclk falling).
REQ-022 Bit order SHALL be LSB first (bit 0 first) unless REQ-033 applies.
REQ-023 After 8th SCK_LO: rsp_valid=1 for exactly one cycle with all 8 captured bits; bit counter wraps 7->0.
REQ-024 Byte done with req_last=0: enter NEXT, ss=0, sclk=0, wait indefinitely for req_valid.
REQ-025 NEXT accept: next cycle SCK_HI for bit 0 of the new byte, no SETUP delay.
REQ-026 Byte done with req_last=1: HOLD for HOLD cycles (ss=0), then GAP one cycle (ss=1, req_ready=0), then IDLE.
REQ-027 Single byte with defaults: ss low for exactly 2+32+2=36 cycles.
REQ-028 req_data and req_last SHALL be registered on accept; later input changes are ignored.
REQ-029 rsp_valid has no back-pressure; rsp_data holds its value until the next rsp_valid.

Reset
REQ-030 rstn low SHALL immediately force ss=1, sclk=0, mosi=0, req_ready=0, rsp_valid=0, rsp_data=0, busy=0, state IDLE.
REQ-031 Reset mid-transfer SHALL abort with no rsp_valid; req_ready=1 on the first clk edge after rstn rises.
REQ-032 All counters and shift registers SHALL reset to 0.

Configuration
REQ-033 SPI_MSB_FIRST_EN defined: shift MSB first on mosi and assemble miso MSB first. Undefined: LSB first on both.

Structure
REQ-034 Package spi_pkg SHALL hold the state enum typedef, bit-count width constant, and default DIV/SETUP/HOLD constants.
REQ-035 Sub-module spi_clk_div SHALL provide the DIV-cycle half-period counter with load/expire outputs; all other logic is in spi_master_ctrl.

Verification
REQ-036 Send 0xAB, last=1, defaults -> mosi at each sclk rise 1,1,0,1,0,1,0,1; ss low 36 cycles; 8 sclk pulses.
REQ-037 Send 0xAB (last=0) then 0xCD (last=1), miso looped to mosi -> rsp_data 0xAB then 0xCD; ss never rises between bytes; no SETUP before second byte.
REQ-038 Send 0x5A, last=0, hold req_valid low 20 cycles -> state NEXT, ss=0, sclk=0, req_ready=1 throughout.
REQ-039 Assert rstn=0 during bit 3 of 0xFF -> ss=1 and sclk=0 same cycle, no rsp_valid; next 0x01 transfers correctly.
REQ-040 SPI_MSB_FIRST_EN defined, send 0x80 -> mosi 1 at first sclk rise, 0 at the following seven.
REQ-041 DIV=1, SETUP=1, HOLD=1, send 0x0F -> ss low 18 cycles, sclk period 2 clk cycles.
